// File: rtl/t03_char_pkg.sv
// Shared constants, state type and helpers for the character-code to binary decoder.
package t03_char_pkg;

  localparam logic [5:0] CHAR_DIGIT0 = 6'd26;
  localparam logic [5:0] CHAR_DIGIT9 = 6'd35;
  localparam logic [5:0] CHAR_BLANK  = 6'd3;

  typedef enum logic {
    ACC,
    OUT
  } dec_state_t;

  function automatic logic is_digit_code(input logic [5:0] code);
    return (code >= CHAR_DIGIT0) && (code <= CHAR_DIGIT9);
  endfunction

endpackage

// File: rtl/t03_char_to_digit.sv
// Combinational map from a display character code to a decimal digit value.
module t03_char_to_digit
  import t03_char_pkg::*;
(
  input  logic [5:0] i_char_code,
  output logic [3:0] o_digit,
  output logic       o_is_digit
);

  logic [3:0] w_low_digit;

  // Codes 26..35 are 0x1A..0x23; the low nibble minus 10 (mod 16) yields 0..9.
  assign w_low_digit = i_char_code[3:0] - 4'd10;
  assign o_is_digit  = is_digit_code(i_char_code);
  assign o_digit     = o_is_digit ? w_low_digit : 4'd0;

endmodule

// File: rtl/t03_char_to_bin_decoder.sv
// Rebuilds the binary value of a fixed-length decimal field from a serial stream
// of character codes (most significant digit first), one result per frame.
module t03_char_to_bin_decoder
  import t03_char_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned OUT_W      = 7,
  parameter int unsigned MAX_VALUE  = 15
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [5:0]       char_code,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic             out_err,
  output logic             out_range
);

  localparam int unsigned      CntW   = $clog2(NUM_DIGITS + 1);
  localparam logic [OUT_W-1:0] MaxVal = OUT_W'(MAX_VALUE);

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > 4)) begin : g_bad_num_digits
    $error("NUM_DIGITS must be in 1..4");
  end
  if (((64'd10 ** NUM_DIGITS) - 64'd1) >= (64'd1 << OUT_W)) begin : g_bad_out_w
    $error("OUT_W too narrow for 10^NUM_DIGITS-1");
  end

  dec_state_t       r_state;
  dec_state_t       w_state_next;
  logic [OUT_W-1:0] r_acc;
  logic [CntW-1:0]  r_cnt;
  logic             r_err;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_value;
  logic             r_out_err;
  logic             r_out_range;

  logic             w_in_ready;
  logic [3:0]       w_digit;
  logic             w_is_digit;
  logic             w_take;
  logic             w_last;
  logic             w_err_next;
  logic [OUT_W-1:0] w_acc_next;

  t03_char_to_digit u_char_to_digit (
    .i_char_code (char_code),
    .o_digit     (w_digit),
    .o_is_digit  (w_is_digit)
  );

  // A flush in ACC wins over a same-cycle transfer, so it never counts as one.
  assign w_take     = in_valid && w_in_ready && !flush;
  assign w_last     = (r_cnt == CntW'(NUM_DIGITS - 1));
  assign w_err_next = r_err || !w_is_digit;
  assign w_acc_next = w_is_digit ? (r_acc * OUT_W'(10)) + OUT_W'(w_digit) : r_acc;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ACC: if (w_take && w_last) w_state_next = OUT;
      OUT: if (out_ready)        w_state_next = ACC;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == ACC);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_value <= '0;
      r_out_err   <= 1'b0;
      r_out_range <= 1'b0;
    end else begin
      unique case (r_state)
        ACC: begin
          if (flush) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
          end else if (w_take) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CntW'(1);
            r_err <= w_err_next;
            if (w_last) begin
              r_out_valid <= 1'b1;
              r_out_value <= w_err_next ? '0 : w_acc_next;
              r_out_err   <= w_err_next;
              r_out_range <= !w_err_next && (w_acc_next > MaxVal);
            end
          end
        end
        OUT: begin
          // Result held until accepted; flush is deliberately ignored here.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_value = r_out_value;
  assign out_err   = r_out_err;
  assign out_range = r_out_range;

endmodule
